// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for the bit-serial adder.
// master drives operands and out_ready; slave returns the result.
interface serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, carry
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, carry
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-add per clock, LSB first.
// Result registers update only when the last bit completes.
module serial_adder #(
    parameter int WIDTH = 16
) (
    input logic           clk,
    input logic           reset,
    serial_adder_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADD  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] psum;
    logic [WIDTH-1:0] sum_q;
    logic             cy;
    logic             carry_q;
    logic [CW-1:0]    cnt;
    logic             s_bit;
    logic             c_out;

    assign s_bit = opa[0] ^ opb[0] ^ cy;
    assign c_out = (opa[0] & opb[0]) | (cy & (opa[0] ^ opb[0]));

    // Handshake outputs decode only the registered state.
    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.sum       = sum_q;
    assign bus.carry     = carry_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            opa     <= '0;
            opb     <= '0;
            psum    <= '0;
            sum_q   <= '0;
            cy      <= 1'b0;
            carry_q <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        opa   <= bus.a;
                        opb   <= bus.b;
                        cy    <= bus.cin;
                        cnt   <= '0;
                        state <= ADD;
                    end
                end
                ADD: begin
                    psum <= {s_bit, psum[WIDTH-1:1]};
                    cy   <= c_out;
                    opa  <= opa >> 1;
                    opb  <= opb >> 1;
                    cnt  <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        sum_q   <= {s_bit, psum[WIDTH-1:1]};
                        carry_q <= c_out;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits; SHALL be >= 2.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  operand set presented.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 a  input  WIDTH  first operand.
REQ-007 b  input  WIDTH  second operand.
REQ-008 cin  input  1  carry-in to bit 0.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer takes result.
REQ-011 sum  output  WIDTH  low WIDTH bits of a+b+cin.
REQ-012 carry  output  1  bit WIDTH of a+b+cin.

Function
REQ-013 States SHALL be IDLE, ADD and DONE, held in a registered state variable.
REQ-014 IDLE: in_ready=1 and out_valid=0.
REQ-015 ADD and DONE: in_ready=0; in_valid, a, b and cin SHALL be ignored.
REQ-016 Accept edge (IDLE, in_valid=1):
- capture a and b into operand shift registers;
- capture cin into the carry register;
- clear the bit counter;
- go to ADD.
REQ-017 Each ADD edge:
- full-add operand-A LSB, operand-B LSB and the carry register;
- shift the sum bit into the MSB of the partial-sum register (right shift);
- store the carry-out in the carry register;
- right-shift both operand registers;
- increment the bit counter.
REQ-018 The ADD edge with counter = WIDTH-1 SHALL:
- copy the completed partial sum to sum;
- copy the final carry to carry;
- go to DONE.
REQ-019 out_valid SHALL first be 1 after exactly WIDTH rising edges following the accept edge.
REQ-020 DONE: out_valid=1; sum and carry SHALL stay constant until the handshake.
REQ-021 DONE with out_ready=1 at an edge SHALL go to IDLE; out_ready=0 SHALL hold DONE indefinitely.
REQ-022 No combinational path from out_ready to in_ready.
- Minimum spacing between consecutive accepts: WIDTH+2 cycles.
REQ-023 {carry,sum} SHALL equal (a + b + cin) mod 2^(WIDTH+1), using the values captured at acceptance.
REQ-024 sum and carry SHALL change only on the REQ-018 edge or reset.
- They hold the last completed result in IDLE and ADD.
REQ-025 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-026 reset=1 at an edge SHALL force, whatever the state:
- state = IDLE;
- in_ready=1, out_valid=0;
- sum=0, carry=0;
- counter, operand, partial-sum and carry registers = 0.
REQ-027 Reset during ADD or DONE SHALL discard the in-progress or pending result; nothing of it appears at the outputs.
REQ-028 in_valid asserted while reset=1 SHALL NOT be accepted.

Verification (WIDTH=16)
REQ-029 a=0x0003, b=0x0005, cin=0 accepted at edge E0 -> out_valid rises after edge E16; sum=0x0008, carry=0.
REQ-030 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, carry=1.
- Follow-up a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, carry=1.
REQ-031 Backpressure: out_ready=0 for 5 cycles in DONE, with in_valid=1 and new operands driven ->
- out_valid stays 1;
- sum/carry stable;
- in_ready stays 0;
- no operands accepted.
- Then out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-032 Reset mid-operation: reset=1 on the 8th ADD edge of 0x1234+0x1111 -> after that edge in_ready=1, out_valid=0, sum=0x0000, carry=0.
- Re-issue the same operands -> sum=0x2345, carry=0.
REQ-033 Back-to-back: in_valid and out_ready held at 1 with operands 0x0001+0x0001, then 0x7FFF+0x0001 ->
- accepts exactly 18 cycles apart;
- results 0x0002/0, then 0x8000/0.
REQ-034 Bench SHALL check against a reference sum for >= 1000 random {a,b,cin} sets with random out_ready stalls.
- Every result SHALL match REQ-023.
- No result may be dropped or duplicated.
